udp_rx_port_demux: RTL and testbench
====================================

UDP_RX_PORT_DEMUX -- requirements
Module: udp_rx_port_demux

Interface
REQ-001 SHALL have parameter LOG_PORT, default 16'd60001: UDP destination port that selects the log app.
REQ-002 SHALL have parameter ECHO_PORT, default 16'd60000: UDP destination port that selects the echo app.
REQ-003 SHALL have clk, input, 1: the single clock.
REQ-004 SHALL have rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have the RX header bundle from UDP.
- udp_demux_rx_hdr_val, in, 1.
- udp_demux_rx_src_ip, in, IP_ADDR_W.
- udp_demux_rx_dst_ip, in, IP_ADDR_W.
- udp_demux_rx_udp_hdr, in, udp_pkt_hdr.
- demux_udp_rx_hdr_rdy, out, 1.
REQ-006 SHALL have the RX data bundle from UDP.
- udp_demux_rx_data_val, in, 1.
- udp_demux_rx_data, in, MAC_INTERFACE_W.
- udp_demux_rx_last, in, 1.
- udp_demux_rx_padbytes, in, MAC_PADBYTES_W.
- demux_udp_rx_data_rdy, out, 1.
REQ-007 SHALL have the echo header bundle: demux_echo_rx_hdr_val/src_ip/dst_ip/udp_hdr out, same widths as REQ-005; echo_demux_rx_hdr_rdy in, 1.
REQ-008 SHALL have the echo data bundle: demux_echo_rx_data_val/data/last/padbytes out, same widths as REQ-006; echo_demux_rx_data_rdy in, 1.
REQ-009 SHALL have the log header bundle: demux_log_rx_hdr_* out and log_demux_rx_hdr_rdy in, widths as REQ-007.
REQ-010 SHALL have the log data bundle: demux_log_rx_data_* out and log_demux_rx_data_rdy in, widths as REQ-008.
REQ-011 SHALL have drop_pkt_cnt, out, 32: count of dropped packets.

Function
REQ-012 SHALL implement the FSM states IDLE, HDR_OUT, DATA and DRAIN.
REQ-013 In IDLE, demux_udp_rx_hdr_rdy SHALL be 1; in every other state it SHALL be 0.
REQ-014 On header accept (hdr_val and hdr_rdy), the block SHALL register src_ip, dst_ip, udp_hdr and the decoded destination.
- If udp_hdr.dst_port == LOG_PORT: destination is LOG, next state HDR_OUT.
- Else if dst_port == ECHO_PORT: destination is ECHO, next state HDR_OUT.
- Otherwise: next state DRAIN, and drop_pkt_cnt increments.
REQ-015 If LOG_PORT equals ECHO_PORT, LOG SHALL take priority.
REQ-016 In HDR_OUT, the selected port's hdr_val SHALL be 1, driven from registers only.
- The header appears on the output the cycle after it is accepted.
- The unselected port's hdr_val SHALL be 0.
- On the selected port's hdr_rdy, next state is DATA.
REQ-017 demux_udp_rx_data_rdy SHALL be 0 in IDLE and HDR_OUT, so data arriving early is held upstream.
REQ-018 In DATA, data SHALL pass combinationally with zero latency.
- Selected data_val = udp_demux_rx_data_val.
- demux_udp_rx_data_rdy = the selected port's data_rdy.
- data, last and padbytes pass unchanged.
- The unselected port's data_val SHALL be 0.
REQ-019 In DATA, a handshake with last=1 SHALL return the FSM to IDLE; the next header can then be accepted the following cycle.
REQ-020 In DRAIN, demux_udp_rx_data_rdy SHALL be 1 and no output data_val SHALL assert.
- A handshake with last=1 returns the FSM to IDLE.
REQ-021 A single-beat packet (last on the first beat) SHALL be handled identically to a multi-beat packet.
REQ-022 drop_pkt_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-023 Header payload outputs SHALL hold their registered values whenever hdr_val is 0.

Reset
REQ-024 While rst=0, the following SHALL hold:
- FSM in IDLE.
- All val outputs 0.
- demux_udp_rx_data_rdy 0.
- demux_udp_rx_hdr_rdy 1 once rst deasserts.
- drop_pkt_cnt 0.
- Header registers 0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet without emitting a partial last; upstream is reset in the same domain.

Structure
REQ-026 udp_pkt_hdr, IP_ADDR_W, MAC_INTERFACE_W and MAC_PADBYTES_W SHALL come from the shared soc/packet definitions.
- The dest enum (DEST_ECHO, DEST_LOG) and the FSM state enum SHALL be local to the module.
REQ-027 The block SHALL be a single module with no sub-modules; its output bundles feed the echo app and the logging app directly.

Verification
REQ-028 Header dst_port=60001, 3-beat packet, all rdy=1:
- log hdr_val the cycle after accept.
- 3 log beats, last on beat 3.
- echo vals stay 0.
REQ-029 dst_port=60000, echo_demux_rx_hdr_rdy held 0 for 5 cycles:
- echo hdr_val stays high with a stable header.
- demux_udp_rx_data_rdy=0 throughout.
- Then the packet forwards.
REQ-030 dst_port=1234, 4-beat packet:
- Every beat is consumed with rdy=1.
- No output val asserts.
- drop_pkt_cnt goes 0→1.
REQ-031 Back-to-back single-beat packets (LOG then ECHO):
- The second header is accepted the cycle after the first last.
- Each packet reaches only its own port.
REQ-032 Random data_rdy stalls on the log port during a 64-beat packet: beats, padbytes and last match the input exactly, in order.
REQ-033 rst=0 asserted in DATA mid-packet:
- All vals drop to 0 immediately.
- After release the FSM is in IDLE and hdr_rdy=1.

Source files
------------

// File: rtl/udp_rx_port_demux_pkg.sv
// Shared packet-path definitions: bus widths and the UDP header layout seen
// by every consumer of the UDP RX stream.
package udp_rx_port_demux_pkg;

    localparam int IP_ADDR_W       = 32;
    localparam int MAC_INTERFACE_W = 64;
    localparam int MAC_PADBYTES_W  = 3;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;

endpackage

// File: rtl/udp_rx_port_demux.sv
// Steers each UDP RX packet to the log or echo app by destination port;
// packets for any other port are drained upstream and counted as drops.
module udp_rx_port_demux
    import udp_rx_port_demux_pkg::*;
#(
    parameter logic [15:0] LOG_PORT  = 16'd60001,
    parameter logic [15:0] ECHO_PORT = 16'd60000
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       udp_demux_rx_hdr_val,
    input  logic [IP_ADDR_W-1:0]       udp_demux_rx_src_ip,
    input  logic [IP_ADDR_W-1:0]       udp_demux_rx_dst_ip,
    input  udp_pkt_hdr                 udp_demux_rx_udp_hdr,
    output logic                       demux_udp_rx_hdr_rdy,

    input  logic                       udp_demux_rx_data_val,
    input  logic [MAC_INTERFACE_W-1:0] udp_demux_rx_data,
    input  logic                       udp_demux_rx_last,
    input  logic [MAC_PADBYTES_W-1:0]  udp_demux_rx_padbytes,
    output logic                       demux_udp_rx_data_rdy,

    output logic                       demux_echo_rx_hdr_val,
    output logic [IP_ADDR_W-1:0]       demux_echo_rx_src_ip,
    output logic [IP_ADDR_W-1:0]       demux_echo_rx_dst_ip,
    output udp_pkt_hdr                 demux_echo_rx_udp_hdr,
    input  logic                       echo_demux_rx_hdr_rdy,

    output logic                       demux_echo_rx_data_val,
    output logic [MAC_INTERFACE_W-1:0] demux_echo_rx_data,
    output logic                       demux_echo_rx_last,
    output logic [MAC_PADBYTES_W-1:0]  demux_echo_rx_padbytes,
    input  logic                       echo_demux_rx_data_rdy,

    output logic                       demux_log_rx_hdr_val,
    output logic [IP_ADDR_W-1:0]       demux_log_rx_src_ip,
    output logic [IP_ADDR_W-1:0]       demux_log_rx_dst_ip,
    output udp_pkt_hdr                 demux_log_rx_udp_hdr,
    input  logic                       log_demux_rx_hdr_rdy,

    output logic                       demux_log_rx_data_val,
    output logic [MAC_INTERFACE_W-1:0] demux_log_rx_data,
    output logic                       demux_log_rx_last,
    output logic [MAC_PADBYTES_W-1:0]  demux_log_rx_padbytes,
    input  logic                       log_demux_rx_data_rdy,

    output logic [31:0]                drop_pkt_cnt
);

    typedef enum logic [1:0] {IDLE, HDR_OUT, DATA, DRAIN} state_e;
    typedef enum logic {DEST_ECHO, DEST_LOG} dest_e;

    state_e                state, state_next;
    dest_e                 dest;
    logic [IP_ADDR_W-1:0]  src_ip_r, dst_ip_r;
    udp_pkt_hdr            udp_hdr_r;

    logic hdr_acc, log_hit, echo_hit;
    logic sel_hdr_rdy, sel_data_rdy;

    assign hdr_acc  = udp_demux_rx_hdr_val && demux_udp_rx_hdr_rdy;
    // Log is tested first so it wins when both ports are configured equal.
    assign log_hit  = (udp_demux_rx_udp_hdr.dst_port == LOG_PORT);
    assign echo_hit = (udp_demux_rx_udp_hdr.dst_port == ECHO_PORT);

    assign sel_hdr_rdy  = (dest == DEST_LOG) ? log_demux_rx_hdr_rdy  : echo_demux_rx_hdr_rdy;
    assign sel_data_rdy = (dest == DEST_LOG) ? log_demux_rx_data_rdy : echo_demux_rx_data_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hdr_acc) state_next = (log_hit || echo_hit) ? HDR_OUT : DRAIN;
            HDR_OUT: if (sel_hdr_rdy) state_next = DATA;
            DATA:    if (udp_demux_rx_data_val && sel_data_rdy && udp_demux_rx_last) state_next = IDLE;
            DRAIN:   if (udp_demux_rx_data_val && udp_demux_rx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        demux_udp_rx_hdr_rdy   = rst && (state == IDLE);
        demux_udp_rx_data_rdy  = 1'b0;
        demux_echo_rx_hdr_val  = 1'b0;
        demux_log_rx_hdr_val   = 1'b0;
        demux_echo_rx_data_val = 1'b0;
        demux_log_rx_data_val  = 1'b0;
        case (state)
            HDR_OUT: begin
                demux_log_rx_hdr_val  = (dest == DEST_LOG);
                demux_echo_rx_hdr_val = (dest == DEST_ECHO);
            end
            DATA: begin
                demux_log_rx_data_val  = (dest == DEST_LOG)  && udp_demux_rx_data_val;
                demux_echo_rx_data_val = (dest == DEST_ECHO) && udp_demux_rx_data_val;
                demux_udp_rx_data_rdy  = sel_data_rdy;
            end
            DRAIN:   demux_udp_rx_data_rdy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ip_r     <= '0;
            dst_ip_r     <= '0;
            udp_hdr_r    <= '0;
            dest         <= DEST_ECHO;
            drop_pkt_cnt <= '0;
        end else if (hdr_acc) begin
            src_ip_r  <= udp_demux_rx_src_ip;
            dst_ip_r  <= udp_demux_rx_dst_ip;
            udp_hdr_r <= udp_demux_rx_udp_hdr;
            dest      <= log_hit ? DEST_LOG : DEST_ECHO;
            if (!log_hit && !echo_hit && drop_pkt_cnt != 32'hFFFF_FFFF)
                drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
        end
    end

    // Both apps see the same registered header; only the val differs.
    assign demux_echo_rx_src_ip  = src_ip_r;
    assign demux_echo_rx_dst_ip  = dst_ip_r;
    assign demux_echo_rx_udp_hdr = udp_hdr_r;
    assign demux_log_rx_src_ip   = src_ip_r;
    assign demux_log_rx_dst_ip   = dst_ip_r;
    assign demux_log_rx_udp_hdr  = udp_hdr_r;

    assign demux_echo_rx_data     = udp_demux_rx_data;
    assign demux_echo_rx_last     = udp_demux_rx_last;
    assign demux_echo_rx_padbytes = udp_demux_rx_padbytes;
    assign demux_log_rx_data      = udp_demux_rx_data;
    assign demux_log_rx_last      = udp_demux_rx_last;
    assign demux_log_rx_padbytes  = udp_demux_rx_padbytes;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Randomized bench for udp_rx_port_demux: per-port expected header/beat queues
// filled by the driver, drained by a single negedge compare process.
module tb_udp_rx_port_demux;
    import udp_rx_port_demux_pkg::*;

    localparam logic [15:0] LOGP  = 16'd60001;
    localparam logic [15:0] ECHOP = 16'd60000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                       hdr_val = 1'b0;
    logic [IP_ADDR_W-1:0]       src_ip = '0, dst_ip = '0;
    udp_pkt_hdr                 udp_hdr = '0;
    logic                       hdr_rdy;
    logic                       data_val = 1'b0;
    logic [MAC_INTERFACE_W-1:0] data = '0;
    logic                       last = 1'b0;
    logic [MAC_PADBYTES_W-1:0]  pad = '0;
    logic                       data_rdy;

    logic                       e_hv, l_hv, e_dv, l_dv, e_last, l_last;
    logic [IP_ADDR_W-1:0]       e_src, e_dst, l_src, l_dst;
    udp_pkt_hdr                 e_hdr, l_hdr;
    logic [MAC_INTERFACE_W-1:0] e_data, l_data;
    logic [MAC_PADBYTES_W-1:0]  e_pad, l_pad;
    logic                       e_hrdy = 1'b1, l_hrdy = 1'b1, e_drdy = 1'b1, l_drdy = 1'b1;
    logic [31:0]                drop_cnt;

    udp_rx_port_demux #(.LOG_PORT(LOGP), .ECHO_PORT(ECHOP)) dut (
        .clk(clk), .rst(rst),
        .udp_demux_rx_hdr_val(hdr_val), .udp_demux_rx_src_ip(src_ip),
        .udp_demux_rx_dst_ip(dst_ip), .udp_demux_rx_udp_hdr(udp_hdr),
        .demux_udp_rx_hdr_rdy(hdr_rdy),
        .udp_demux_rx_data_val(data_val), .udp_demux_rx_data(data),
        .udp_demux_rx_last(last), .udp_demux_rx_padbytes(pad),
        .demux_udp_rx_data_rdy(data_rdy),
        .demux_echo_rx_hdr_val(e_hv), .demux_echo_rx_src_ip(e_src),
        .demux_echo_rx_dst_ip(e_dst), .demux_echo_rx_udp_hdr(e_hdr),
        .echo_demux_rx_hdr_rdy(e_hrdy),
        .demux_echo_rx_data_val(e_dv), .demux_echo_rx_data(e_data),
        .demux_echo_rx_last(e_last), .demux_echo_rx_padbytes(e_pad),
        .echo_demux_rx_data_rdy(e_drdy),
        .demux_log_rx_hdr_val(l_hv), .demux_log_rx_src_ip(l_src),
        .demux_log_rx_dst_ip(l_dst), .demux_log_rx_udp_hdr(l_hdr),
        .log_demux_rx_hdr_rdy(l_hrdy),
        .demux_log_rx_data_val(l_dv), .demux_log_rx_data(l_data),
        .demux_log_rx_last(l_last), .demux_log_rx_padbytes(l_pad),
        .log_demux_rx_data_rdy(l_drdy),
        .drop_pkt_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [IP_ADDR_W-1:0] s;
        logic [IP_ADDR_W-1:0] d;
        udp_pkt_hdr           h;
    } hdr_t;
    typedef struct packed {
        logic [MAC_INTERFACE_W-1:0] data;
        logic                       last;
        logic [MAC_PADBYTES_W-1:0]  pad;
    } beat_t;

    hdr_t  eh_q[$], lh_q[$];
    beat_t eb_q[$], lb_q[$];

    int checks = 0, failures = 0;
    int model_drops = 0, echo_beats = 0, log_beats = 0, echo_stall = 0;
    bit mon_en = 0, rand_rdy = 0, echo_block = 0;
    bit hdr_probe = 0, seen_e_hv = 0, seen_l_hv = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            e_hrdy = ($urandom % 4) != 0;
            l_hrdy = ($urandom % 4) != 0;
            e_drdy = ($urandom % 3) != 0;
            l_drdy = ($urandom % 3) != 0;
        end else begin
            e_hrdy = !echo_block;
            l_hrdy = 1'b1;
            e_drdy = 1'b1;
            l_drdy = 1'b1;
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (hdr_probe) begin
                seen_e_hv = e_hv;
                seen_l_hv = l_hv;
                hdr_probe = 0;
            end
            chk("hdr_val_exclusive", 128'(e_hv & l_hv), 128'(0));
            chk("data_val_exclusive", 128'(e_dv & l_dv), 128'(0));
            if (e_hv) begin
                chk("data_rdy_during_echo_hdr", 128'(data_rdy), 128'(0));
                if (eh_q.size() == 0) flag("echo_hdr_unexpected");
                else begin
                    chk("echo_hdr", 128'({e_src, e_dst, e_hdr}), 128'(eh_q[0]));
                    if (e_hrdy) void'(eh_q.pop_front());
                    else echo_stall++;
                end
            end
            if (l_hv) begin
                chk("data_rdy_during_log_hdr", 128'(data_rdy), 128'(0));
                if (lh_q.size() == 0) flag("log_hdr_unexpected");
                else begin
                    chk("log_hdr", 128'({l_src, l_dst, l_hdr}), 128'(lh_q[0]));
                    if (l_hrdy) void'(lh_q.pop_front());
                end
            end
            if (e_dv) begin
                chk("echo_val_follows_input", 128'(data_val), 128'(1));
                chk("echo_rdy_passthru", 128'(data_rdy), 128'(e_drdy));
                if (eb_q.size() == 0 || eh_q.size() != 0) flag("echo_beat_unexpected");
                else begin
                    chk("echo_beat", 128'({e_data, e_last, e_pad}), 128'(eb_q[0]));
                    if (e_drdy) begin void'(eb_q.pop_front()); echo_beats++; end
                end
            end
            if (l_dv) begin
                chk("log_val_follows_input", 128'(data_val), 128'(1));
                chk("log_rdy_passthru", 128'(data_rdy), 128'(l_drdy));
                if (lb_q.size() == 0 || lh_q.size() != 0) flag("log_beat_unexpected");
                else begin
                    chk("log_beat", 128'({l_data, l_last, l_pad}), 128'(lb_q[0]));
                    if (l_drdy) begin void'(lb_q.pop_front()); log_beats++; end
                end
            end
            chk("drop_cnt", 128'(drop_cnt), 128'(model_drops));
        end
    end

    // Sends header then beats; stops before beat index abort_at (if >= 0).
    task automatic send_pkt(input logic [15:0] port, input int nbeats, input bit bubbles,
                            input int abort_at, output int hdr_wait);
        hdr_t  h;
        beat_t b[$];
        bit    ok;
        int    cyc;
        h.s = $urandom; h.d = $urandom;
        h.h.src_port = 16'($urandom); h.h.dst_port = port;
        h.h.length = 16'($urandom); h.h.chksum = 16'($urandom);
        for (int i = 0; i < nbeats; i++) begin
            beat_t bt;
            bt.data = {$urandom, $urandom};
            bt.last = (i == nbeats - 1);
            bt.pad  = MAC_PADBYTES_W'($urandom);
            b.push_back(bt);
        end
        hdr_val = 1'b1; src_ip = h.s; dst_ip = h.d; udp_hdr = h.h;
        ok = 0; cyc = 0;
        while (!ok && cyc < 200) begin
            @(negedge clk); ok = hdr_rdy;
            @(posedge clk); #1; cyc++;
        end
        hdr_val = 1'b0;
        hdr_wait = cyc;
        if (!ok) begin flag("hdr_accept_timeout"); return; end
        hdr_probe = 1;
        if (port == LOGP) begin lh_q.push_back(h); foreach (b[i]) lb_q.push_back(b[i]); end
        else if (port == ECHOP) begin eh_q.push_back(h); foreach (b[i]) eb_q.push_back(b[i]); end
        else model_drops++;
        for (int i = 0; i < nbeats; i++) begin
            if (i == abort_at) return;
            if (bubbles && ($urandom % 4) == 0) begin
                data_val = 1'b0;
                @(posedge clk); #1;
            end
            data_val = 1'b1; data = b[i].data; last = b[i].last; pad = b[i].pad;
            ok = 0; cyc = 0;
            while (!ok && cyc < 500) begin
                @(negedge clk); ok = data_rdy;
                @(posedge clk); #1; cyc++;
            end
            data_val = 1'b0; last = 1'b0;
            if (!ok) begin flag("data_accept_timeout"); return; end
        end
    endtask

    task automatic chk_empty(input string name);
        chk(name, 128'(eh_q.size() + lh_q.size() + eb_q.size() + lb_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, eb0, lb0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_e_hv", 128'(e_hv | e_dv), 128'(0));
        chk("reset_l_hv", 128'(l_hv | l_dv), 128'(0));
        chk("reset_data_rdy", 128'(data_rdy), 128'(0));
        chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("reset_hdr_regs", 128'({e_src, e_dst, e_hdr}), 128'(0));
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("hdr_rdy_after_reset", 128'(hdr_rdy), 128'(1));
        @(posedge clk); #1;
        mon_en = 1;

        // Log, 3 beats, all ready.
        send_pkt(LOGP, 3, 0, -1, w);
        repeat (2) @(posedge clk); #1;
        chk("log_hdr_next_cycle", 128'(seen_l_hv), 128'(1));
        chk("echo_hdr_quiet", 128'(seen_e_hv), 128'(0));
        chk("log_beats_3", 128'(log_beats), 128'(3));
        chk("echo_beats_0", 128'(echo_beats), 128'(0));
        chk_empty("queues_empty_log3");

        // Echo with header stalled.
        echo_stall = 0; echo_block = 1;
        fork
            send_pkt(ECHOP, 2, 0, -1, w);
            begin repeat (7) @(negedge clk); echo_block = 0; end
        join
        repeat (2) @(posedge clk); #1;
        chk("echo_hdr_stall_ge5", 128'(echo_stall >= 5), 128'(1));
        chk("echo_beats_2", 128'(echo_beats), 128'(2));
        chk_empty("queues_empty_echo");

        // Unknown port is drained and counted.
        eb0 = echo_beats; lb0 = log_beats;
        send_pkt(16'd1234, 4, 0, -1, w);
        repeat (2) @(posedge clk); #1;
        chk("drop_cnt_one", 128'(drop_cnt), 128'(1));
        chk("drop_no_beats", 128'((echo_beats - eb0) + (log_beats - lb0)), 128'(0));

        // Back-to-back single-beat packets.
        eb0 = echo_beats; lb0 = log_beats;
        send_pkt(LOGP, 1, 0, -1, w);
        send_pkt(ECHOP, 1, 0, -1, w);
        chk("b2b_hdr_wait", 128'(w), 128'(1));
        repeat (2) @(posedge clk); #1;
        chk("b2b_log_beat", 128'(log_beats - lb0), 128'(1));
        chk("b2b_echo_beat", 128'(echo_beats - eb0), 128'(1));
        chk_empty("queues_empty_b2b");

        // 64-beat log packet with random stalls.
        rand_rdy = 1;
        lb0 = log_beats;
        send_pkt(LOGP, 64, 1, -1, w);
        repeat (4) @(posedge clk); #1;
        chk("log_beats_64", 128'(log_beats - lb0), 128'(64));
        chk_empty("queues_empty_64");

        // Random traffic.
        for (int p = 0; p < 30; p++) begin
            logic [15:0] port;
            case ($urandom % 3)
                0: port = LOGP;
                1: port = ECHOP;
                default: port = 16'($urandom_range(0, 59999));
            endcase
            send_pkt(port, int'($urandom_range(1, 8)), 1, -1, w);
        end
        repeat (10) @(posedge clk); #1;
        chk_empty("queues_empty_random");

        // Reset in the middle of a log packet.
        rand_rdy = 0;
        repeat (2) @(posedge clk); #1;
        send_pkt(LOGP, 5, 0, 2, w);
        data_val = 1'b1; data = {$urandom, $urandom}; last = 1'b0;
        @(negedge clk);
        chk("mid_pkt_log_dv_before_rst", 128'(l_dv), 128'(1));
        mon_en = 0;
        #1 rst = 1'b0;
        #1;
        chk("rst_vals_drop", 128'({e_hv, l_hv, e_dv, l_dv}), 128'(0));
        chk("rst_data_rdy", 128'(data_rdy), 128'(0));
        data_val = 1'b0;
        eh_q.delete(); lh_q.delete(); eb_q.delete(); lb_q.delete();
        model_drops = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_release_hdr_rdy", 128'(hdr_rdy), 128'(1));
        chk("rst_release_drop_cnt", 128'(drop_cnt), 128'(0));
        @(posedge clk); #1;
        mon_en = 1;
        eb0 = echo_beats;
        send_pkt(ECHOP, 2, 0, -1, w);
        repeat (2) @(posedge clk); #1;
        chk("post_reset_echo", 128'(echo_beats - eb0), 128'(2));
        chk_empty("queues_empty_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
